// File: rtl/teclado_pin.sv
// Keypad PIN-entry front end: turns debounced key presses into a two-digit BCD
// PIN with a one-cycle enterPin strobe, an error pulse and an inactivity timeout.
module teclado_pin #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tecla_valida,
  input  logic [3:0] Tecla,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       Error
);

  typedef enum logic [1:0] {
    VACIO     = 2'd0,
    UN_DIGITO = 2'd1,
    COMPLETO  = 2'd2
  } estado_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  K_CLEAR  = 4'hA;
  localparam logic [3:0]  K_ENTER  = 4'hB;

  estado_t     estado, estado_next;
  logic        tv_prev;
  logic [3:0]  d1, d0, d1_next, d0_next;
  logic [15:0] cnt, cnt_next;
  logic [7:0]  pin_next;
  logic        enter_next, error_next;
  logic        accept, timeout, is_digit;

  // Rising edge of the held-key level; tv_prev resets high so a key held
  // through reset is not taken as a fresh press.
  assign accept   = Tecla_valida & ~tv_prev;
  assign is_digit = (Tecla <= 4'd9);
  assign timeout  = (estado != VACIO) && (cnt == CNT_LAST);

  // The state register doubles as the digit count.
  assign Digitos = estado;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado   <= VACIO;
      tv_prev  <= 1'b1;
      d1       <= 4'd0;
      d0       <= 4'd0;
      cnt      <= 16'd0;
      Pin      <= 8'h00;
      enterPin <= 1'b0;
      Error    <= 1'b0;
    end else begin
      estado   <= estado_next;
      tv_prev  <= Tecla_valida;
      d1       <= d1_next;
      d0       <= d0_next;
      cnt      <= cnt_next;
      Pin      <= pin_next;
      enterPin <= enter_next;
      Error    <= error_next;
    end
  end

  always_comb begin
    estado_next = estado;
    d1_next     = d1;
    d0_next     = d0;
    pin_next    = Pin;
    enter_next  = 1'b0;
    error_next  = 1'b0;
    cnt_next    = (estado == VACIO) ? 16'd0 : cnt + 16'd1;

    if (accept) begin
      // An accepted key always wins over a timeout landing on the same edge.
      cnt_next = 16'd0;
      case (estado)
        VACIO: begin
          if (is_digit) begin
            estado_next = UN_DIGITO;
            d1_next     = Tecla;
          end else if (Tecla == K_ENTER) begin
            error_next = 1'b1;
          end
        end
        UN_DIGITO: begin
          if (is_digit) begin
            estado_next = COMPLETO;
            d0_next     = Tecla;
          end else if (Tecla == K_ENTER) begin
            error_next  = 1'b1;
            estado_next = VACIO;
          end else if (Tecla == K_CLEAR) begin
            estado_next = VACIO;
          end
        end
        COMPLETO: begin
          if (is_digit) begin
            error_next = 1'b1;
          end else if (Tecla == K_ENTER) begin
            estado_next = VACIO;
            pin_next    = {d1, d0};
            enter_next  = 1'b1;
          end else if (Tecla == K_CLEAR) begin
            estado_next = VACIO;
          end
        end
        default: estado_next = VACIO;
      endcase
    end else if (timeout) begin
      estado_next = VACIO;
      cnt_next    = 16'd0;
    end

    if (estado_next == VACIO) begin
      d1_next = 4'd0;
      d0_next = 4'd0;
    end
  end

endmodule

// File: tb/tb_teclado_pin.sv
// Self-checking bench for teclado_pin: directed scenarios plus random key
// traffic, all checked against a queue-based behavioural model.
module tb_teclado_pin;

  localparam int T = 8;

  logic       Clk;
  logic       Reset;
  logic       Tecla_valida;
  logic [3:0] Tecla;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digitos;
  logic       Error;

  teclado_pin #(.TIMEOUT_CYC(T)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Tecla_valida(Tecla_valida),
    .Tecla(Tecla),
    .Pin(Pin),
    .enterPin(enterPin),
    .Digitos(Digitos),
    .Error(Error)
  );

  // Clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model: buffered digits, submitted PINs, key-held flag and
  // number of edges since the last accepted key.
  logic [3:0] dig_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] e_pin;
  logic       e_en;
  logic       e_err;
  logic       m_held;
  int         m_age;
  int         n_vec;
  int         n_err;

  function automatic logic [11:0] expected();
    return {e_pin, e_en, 2'(dig_q.size()), e_err};
  endfunction

  task automatic model_update(input logic rst, input logic tv, input logic [3:0] key);
    logic acc;
    if (rst) begin
      e_pin  = 8'h00;
      e_en   = 1'b0;
      e_err  = 1'b0;
      m_held = 1'b1;
      m_age  = 0;
      dig_q.delete();
      return;
    end
    acc    = tv && !m_held;
    m_held = tv;
    e_en   = 1'b0;
    e_err  = 1'b0;
    if (acc) begin
      m_age = 0;
      if (key <= 4'd9) begin
        if (dig_q.size() < 2) dig_q.push_back(key);
        else e_err = 1'b1;
      end else if (key == 4'hA) begin
        dig_q.delete();
      end else if (key == 4'hB) begin
        if (dig_q.size() == 2) begin
          e_pin = {dig_q[0], dig_q[1]};
          e_en  = 1'b1;
          exp_q.push_back(e_pin);
        end else begin
          e_err = 1'b1;
        end
        dig_q.delete();
      end
    end else begin
      if (m_age < 1000000) m_age++;
      if (dig_q.size() > 0 && m_age == T) dig_q.delete();
    end
  endtask

  // Driver: apply inputs just after an edge, clock once, advance the model.
  task automatic step(input logic rst, input logic tv, input logic [3:0] key);
    Reset        = rst;
    Tecla_valida = tv;
    Tecla        = key;
    @(posedge Clk);
    model_update(rst, tv, key);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0, 4'h0);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
  endtask

  task automatic test_basic();
    logic       tv_t[7]  = '{1, 0, 1, 0, 1, 0, 0};
    logic [3:0] key_t[7] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'hB, 4'hB, 4'h0};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, tv_t[i], key_t[i]);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL basic[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
    n_vec++;
    if (Pin !== 8'h10) begin
      n_err++;
      $display("FAIL basic_pin: got %h exp 10", Pin);
    end
  endtask

  task automatic test_held();
    for (int i = 0; i < 26; i++) begin
      step(i == 20 || i == 21, i < 25, 4'h5);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL held[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
  endtask

  task automatic test_malformed();
    logic [3:0] seq[7] = '{4'hB, 4'h7, 4'hB, 4'h3, 4'h4, 4'h9, 4'hB};
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i % 2) == 0, seq[i/2]);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL malformed[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
  endtask

  task automatic test_clear_ignored();
    logic [3:0] seq[3] = '{4'h2, 4'hA, 4'hD};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i % 2) == 0, seq[i/2]);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL clear_ign[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
  endtask

  task automatic test_timeout();
    // Digit 6 then T idle edges: entry discarded.
    for (int i = 0; i <= T; i++) begin
      step(1'b0, i == 0, 4'h6);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
    // Digit 6, then digit 1 landing exactly on the expiry edge.
    for (int i = 0; i <= T + 1; i++) begin
      step(1'b0, i == 0 || i == T, (i == 0) ? 4'h6 : 4'h1);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL timeout_race[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
    n_vec++;
    if (Digitos !== 2'd2) begin
      n_err++;
      $display("FAIL timeout_key_wins: got %0d exp 2", Digitos);
    end
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset_strobe();
    logic       rst_t[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    logic       tv_t[10]  = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 0};
    logic [3:0] key_t[10] = '{4'h5, 4'h5, 4'h8, 4'h8, 4'hB, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0};
    for (int i = 0; i < 10; i++) begin
      step(rst_t[i], tv_t[i], key_t[i]);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL reset_strobe[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
  endtask

  task automatic test_tecla_change();
    logic       tv_t[10]  = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic [3:0] key_t[10] = '{4'h3, 4'h9, 4'hB, 4'h0, 4'h4, 4'hA, 4'h0, 4'hB, 4'h7, 4'h0};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tv_t[i], key_t[i]);
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL tecla_change[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
    end
    n_vec++;
    if (Pin !== 8'h34) begin
      n_err++;
      $display("FAIL tecla_change_pin: got %h exp 34", Pin);
    end
  endtask

  task automatic test_random();
    int idle;
    exp_q.delete();
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if (idle == 0 && $urandom_range(0, 59) == 0) idle = $urandom_range(4, 12);
      if (idle > 0) begin
        idle--;
        step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else begin
        step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      n_vec++;
      if ({Pin, enterPin, Digitos, Error} !== expected()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h exp %h", i, {Pin, enterPin, Digitos, Error}, expected());
      end
      if (enterPin === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL random_pin[%0d]: got strobe pin=%h exp no strobe", i, Pin);
        end else if (exp_q[0] !== Pin) begin
          n_err++;
          $display("FAIL random_pin[%0d]: got %h exp %h", i, Pin, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    Reset        = 1'b1;
    Tecla_valida = 1'b0;
    Tecla        = 4'h0;
    e_pin        = 8'h00;
    e_en         = 1'b0;
    e_err        = 1'b0;
    m_held       = 1'b1;
    m_age        = 0;
    test_reset();
    test_basic();
    test_held();
    test_malformed();
    test_clear_ignored();
    test_timeout();
    test_reset_strobe();
    test_tecla_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/teclado_pin.md
# teclado_pin

- Keypad PIN-entry front end for the parking-gate controller.
- Converts debounced keypad events (digit, clear and enter keys) into a two-digit BCD PIN.
- Presents the PIN to the controller on `Pin[7:0]` with a single-cycle `enterPin` strobe, which is the producer side of the controller's `Pin`/`enterPin` interface.
- Also tracks the digit count, flags malformed entries, and discards a partial entry after an inactivity timeout.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 1000: inactivity window in `Clk` cycles before a partial entry is discarded; legal range 2 to 65535.

Ports:
- `Clk`  input  1  system clock; all state changes on its rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `Tecla_valida`  input  1  key-pressed level from the debounced keypad; high for as long as the key is held.
- `Tecla`  input  4  key code, valid while `Tecla_valida` is high:
  - 0x0–0x9: digits.
  - 0xA: clear.
  - 0xB: enter.
  - 0xC–0xF: ignored.
- `Pin`  output  8  last submitted PIN, `{first digit, second digit}` in BCD.
- `enterPin`  output  1  one-cycle strobe; `Pin` is valid while it is high.
- `Digitos`  output  2  number of digits currently buffered (0, 1 or 2).
- `Error`  output  1  one-cycle pulse on a malformed entry.

## Operation

Key acceptance:
- A key is accepted on a rising edge of `Clk` where `Tecla_valida`=1 and its registered previous value `tv_prev`=0.
- A held key is therefore accepted exactly once.
- `tv_prev` resets to 1, so a key already held when reset is released is not accepted.

State machine (`Digitos` mirrors the state):
- VACIO (0 digits):
  - digit d → UN_DIGITO, `d1`=d.
  - enter → `Error` pulse, stay in VACIO.
  - clear → stay in VACIO, no pulse.
- UN_DIGITO (1 digit):
  - digit d → COMPLETO, `d0`=d.
  - enter → `Error` pulse, go to VACIO.
  - clear → VACIO.
- COMPLETO (2 digits):
  - enter → VACIO; load `Pin` ← `{d1,d0}`; assert `enterPin`.
  - digit → `Error` pulse; buffer is unchanged and the state stays COMPLETO.
  - clear → VACIO.
- Codes 0xC–0xF: accepted as a press (they consume the edge) but change no state and raise no pulse.

Pin register and outputs:
- `Pin` changes only on a successful enter and holds its value until the next one.
- `Pin` never shows partial entries.
- `d1`/`d0` are cleared to 0 on every transition to VACIO.

Timeout counter:
- 16-bit counter.
- Cleared on every accepted key and whenever the state is VACIO.
- Increments each cycle in UN_DIGITO or COMPLETO.
- When it equals `TIMEOUT_CYC-1` and no key is accepted on that edge: state → VACIO, counter → 0, no `Error` pulse.
- A key accepted on the same edge as the timeout takes priority; the timeout is cancelled.

## Timing

- All outputs are registered.
- Reset values: `Pin`=0x00, `enterPin`=0, `Digitos`=0, `Error`=0, state VACIO, counter 0, `tv_prev`=1.
- Latency: a key accepted at edge k updates `Digitos`, `Pin`, `enterPin` and `Error` in the cycle after edge k.
- Pulse width: `enterPin` and `Error` are high for exactly one cycle and are cleared at edge k+1.
- Simultaneous `enterPin` and `Error` is impossible.
- Minimum press spacing: 2 cycles (high then low then high); back-to-back accepted presses are then handled without loss.
- Timeout fires `TIMEOUT_CYC` cycles after the last accepted key; `Digitos` reads 0 in the following cycle.
- Reset mid-entry (or while `enterPin` is high):
  - All outputs are at their reset values in the cycle after the reset edge.
  - A pending `enterPin` is dropped.
  - `Reset` overrides key acceptance on the same edge.
- `Tecla` is sampled only on acceptance edges; changes to `Tecla` while a key is held are ignored.

## Test plan

- Basic entry: press 1, release, press 0, release, press enter.
  - `Digitos` steps 1 → 2 → 0.
  - One cycle of `enterPin`=1 with `Pin`=0x10 in that cycle; `Pin` stays 0x10 afterwards.
- Held key: hold `Tecla_valida` high for 20 cycles with `Tecla`=5 (the change-`Tecla`-while-held case is covered in the last scenario).
  - `Digitos`=1, no second digit accepted.
  - Reset while holding, then release reset: `Digitos` stays 0.
- Malformed entries:
  - Enter with 0 digits → `Error` pulse, `Digitos`=0.
  - Digit 7 then enter → `Error` pulse, `Digitos`=0, `Pin` unchanged.
  - Digits 3, 4, 9 → `Error` pulse on 9; a following enter gives `Pin`=0x34.
- Clear and ignored codes: enter digit 2, press 0xA → `Digitos`=0. Then press 0xD → no change, no pulse.
- Timeout, with `TIMEOUT_CYC`=8:
  - Digit 6, then idle 8 cycles → `Digitos`=0, no `Error`.
  - Repeat, but press digit 1 exactly on the expiry edge → `Digitos`=2 (the key wins over the timeout).
- Reset mid-operation and sampling:
  - Assert `Reset` on the cycle `enterPin` is high → all outputs 0 on the next cycle.
  - Change `Tecla` while a key is held → only the value sampled at acceptance is used.
